sgdmac_mch_cfg: RTL
===================

SGDMAC_MCH_CFG -- requirements
Module: sgdmac_mch_cfg

Interface
REQ-001 SHALL have parameter CH_CNT, default 4, number of DMA channels, legal range 1..8.
REQ-002 SHALL have parameter CNT_W, default 16, width of each per-channel completion counter, legal range 1..32.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have APB ports psel_i, penable_i, pwrite_i (input, 1 each), paddr_i (input, 12), pwdata_i (input, 32).
REQ-006 SHALL have APB ports pready_o (output, 1), prdata_o (output, 32) and pslverr_o (output, 1).
REQ-007 SHALL have port start_addr_o, output, CH_CNT*32, per-channel descriptor base address; channel n occupies bits [32n+31:32n].
REQ-008 SHALL have port start_o, output, CH_CNT, per-channel one-cycle start pulse.
REQ-009 SHALL have port done_i, input, CH_CNT, per-channel one-cycle completion pulse from the engine.
REQ-010 SHALL have port irq_o, output, 1, level interrupt.

Function
REQ-011 SHALL implement a global register map:
- 0x000 VERSION, RO, 0x0002_0000 | CH_CNT.
- 0x004 INT_EN, RW, bits [CH_CNT-1:0].
- 0x008 INT_STATUS, W1C, bits [CH_CNT-1:0].
REQ-012 SHALL place channel n registers at base 0x100 + n*0x10:
- +0x0 START_ADDR, RW.
- +0x4 CMD, WO; writing bit0=1 requests a start.
- +0x8 STATUS, RO; bit0 = busy.
- +0xC DONE_CNT, RO, CNT_W bits, zero-extended.
REQ-013 SHALL assert pready_o in every access phase (psel_i & penable_i), i.e. zero wait states.
REQ-014 SHALL capture read data and error in the setup phase (psel_i & !penable_i), register them, and drive them as prdata_o/pslverr_o in the access phase; prdata_o SHALL be 0 outside read access phases.
REQ-015 SHALL commit writes only in the access phase, so a write takes effect on the clock edge that ends the access phase.
REQ-016 SHALL drive start_o[n] high for exactly one cycle, the cycle after an accepted CMD write, and set busy[n] on that same edge.
REQ-017 SHALL reject a CMD start while busy[n]=1: no pulse, no state change, pslverr_o=1.
REQ-018 SHALL reject a START_ADDR write while busy[n]=1 or when pwdata_i[3:0]!=0 (16-byte descriptor alignment): register unchanged, pslverr_o=1.
REQ-019 SHALL respond to unmapped addresses, writes to RO registers and reads of CMD with pslverr_o=1, prdata_o=0 and no side effect.
REQ-020 SHALL, on done_i[n] while busy[n]=1, clear busy[n], set INT_STATUS[n] and increment DONE_CNT[n] modulo 2^CNT_W (all-ones wraps to 0).
REQ-021 SHALL ignore done_i[n] while busy[n]=0.
REQ-022 SHALL let the set win when done_i[n] and a W1C of INT_STATUS[n] occur in the same cycle.
REQ-023 SHALL set busy[n] when done_i[n] coincides with a start accepted in the same cycle; busy was already 1, so this is a completion followed by a new start, and the counter SHALL still increment.
REQ-024 SHALL drive irq_o = |(INT_STATUS & INT_EN) combinationally from registered state.

Reset
REQ-025 SHALL, with rst=1 at a clock edge, clear all registers: START_ADDR, INT_EN, INT_STATUS, busy, DONE_CNT, prdata_o and pslverr_o to 0; start_o and irq_o SHALL also be 0.
REQ-026 SHALL, when reset occurs mid-transfer, discard the transfer and leave no pending start pulse.

Structure
REQ-027 SHALL define in package sgdmac_cfg_pkg: register offsets, channel base 0x100, channel stride 0x10, VERSION constant and the alignment mask.
REQ-028 SHALL implement per-channel state (START_ADDR, busy, DONE_CNT, start pulse) in sub-module sgdmac_cfg_ch, instantiated CH_CNT times by generate.

Verification
REQ-029 SHALL cover: write 0x100=0x0000_1000, then 0x104=1 -> start_o[0] pulses one cycle, start_addr_o[31:0]=0x1000, read 0x108=1.
REQ-030 SHALL cover: a second 0x104=1 while busy -> pslverr_o=1, no start_o pulse; then done_i[0] -> read 0x108=0, read 0x10C=1, INT_STATUS=0x1.
REQ-031 SHALL cover: INT_EN=0x2 and a channel-1 start then done -> irq_o=1; W1C 0x008=0x2 -> irq_o=0; a W1C coinciding with done_i[1] -> INT_STATUS[1] stays 1.
REQ-032 SHALL cover: write 0x110=0x0000_1004 -> pslverr_o=1 and readback 0; read 0x0FC -> pslverr_o=1 and prdata_o=0.
REQ-033 SHALL cover: CNT_W=2 with four completions on channel 2 -> DONE_CNT reads 1,2,3,0.
REQ-034 SHALL cover: rst asserted one cycle after a CMD write's setup phase -> no start_o pulse, and all registers read 0 afterwards.

Source files
------------

// File: rtl/sgdmac_cfg_pkg.sv
// Register map constants shared by the multi-channel DMA configuration block.
package sgdmac_cfg_pkg;
   localparam int          APB_AW        = 12;
   localparam int          APB_DW        = 32;

   localparam logic [11:0] VERSION_OFF    = 12'h000;
   localparam logic [11:0] INT_EN_OFF     = 12'h004;
   localparam logic [11:0] INT_STATUS_OFF = 12'h008;

   localparam logic [11:0] CH_BASE        = 12'h100;
   localparam logic [11:0] CH_STRIDE      = 12'h010;
   localparam logic [3:0]  CH_ADDR_OFF    = 4'h0;
   localparam logic [3:0]  CH_CMD_OFF     = 4'h4;
   localparam logic [3:0]  CH_STATUS_OFF  = 4'h8;
   localparam logic [3:0]  CH_CNT_OFF     = 4'hC;

   localparam logic [31:0] VERSION_BASE   = 32'h0002_0000;
   // Descriptors are 16-byte aligned; any of these bits set in a base address is illegal.
   localparam logic [31:0] ALIGN_MASK     = 32'h0000_000F;
endpackage

// File: rtl/sgdmac_mch_cfg_if.sv
// APB slave bus bundle for the DMA configuration block.
interface sgdmac_mch_cfg_if;
   import sgdmac_cfg_pkg::*;

   logic              psel_i;
   logic              penable_i;
   logic              pwrite_i;
   logic [APB_AW-1:0] paddr_i;
   logic [APB_DW-1:0] pwdata_i;
   logic              pready_o;
   logic [APB_DW-1:0] prdata_o;
   logic              pslverr_o;

   modport master (output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
                   input  pready_o, prdata_o, pslverr_o);
   modport slave  (input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
                   output pready_o, prdata_o, pslverr_o);
endinterface

// File: rtl/sgdmac_cfg_ch.sv
// One DMA channel: descriptor base, busy flag, start pulse and completion counter.
// Start pulse one cycle after an accepted command; no backpressure.
module sgdmac_cfg_ch
   import sgdmac_cfg_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             addr_wr,
   input  logic             cmd_wr,
   input  logic [31:0]      wdata,
   input  logic             done,
   output logic [31:0]      start_addr,
   output logic             start,
   output logic             busy,
   output logic             blocked,
   output logic             fin,
   output logic [CNT_W-1:0] done_cnt
);
   logic start_acc;
   logic addr_acc;

   // A completion in the same cycle frees the channel, so a new start may follow at once.
   assign fin       = done & busy;
   assign blocked   = busy & ~done;
   assign start_acc = cmd_wr & wdata[0] & ~blocked;
   assign addr_acc  = addr_wr & ~blocked & ((wdata & ALIGN_MASK) == 32'h0);

   always_ff @(posedge clk) begin
      if (rst) begin
         start_addr <= '0;
         start      <= 1'b0;
         busy       <= 1'b0;
         done_cnt   <= '0;
      end else begin
         if (addr_acc) start_addr <= wdata;
         start <= start_acc;
         if (start_acc)  busy <= 1'b1;
         else if (fin)   busy <= 1'b0;
         if (fin) done_cnt <= done_cnt + CNT_W'(1);
      end
   end
endmodule

// File: rtl/sgdmac_mch_cfg.sv
// APB register block for a multi-channel scatter-gather DMA: globals plus per-channel state.
// Zero wait states; read data/error captured in setup, busy rejections resolved in access.
module sgdmac_mch_cfg
   import sgdmac_cfg_pkg::*;
#(
   parameter int CH_CNT = 4,
   parameter int CNT_W  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   sgdmac_mch_cfg_if.slave      apb,
   output logic [CH_CNT*32-1:0] start_addr_o,
   output logic [CH_CNT-1:0]    start_o,
   input  logic [CH_CNT-1:0]    done_i,
   output logic                 irq_o
);
   logic              setup, access, wr_commit;
   logic [3:0]        off;
   logic [CH_CNT-1:0] int_en, int_status;
   logic [CH_CNT-1:0] ch_hit, busy, blocked, fin, addr_wr, cmd_wr, live_rej;
   logic [CNT_W-1:0]  done_cnt [CH_CNT];
   logic [31:0]       setup_dat, prdata_q;
   logic              setup_err, pslverr_q;

   assign setup     = apb.psel_i & ~apb.penable_i;
   assign access    = apb.psel_i & apb.penable_i;
   assign wr_commit = access & apb.pwrite_i & ~pslverr_q;
   assign off       = apb.paddr_i[3:0];

   for (genvar n = 0; n < CH_CNT; n++) begin : g_ch
      assign ch_hit[n]   = apb.paddr_i[11:4] == 8'((CH_BASE + CH_STRIDE * n) >> 4);
      assign addr_wr[n]  = wr_commit & ch_hit[n] & (off == CH_ADDR_OFF);
      assign cmd_wr[n]   = wr_commit & ch_hit[n] & (off == CH_CMD_OFF);
      assign live_rej[n] = ch_hit[n] & blocked[n] &
                           ((off == CH_ADDR_OFF) | ((off == CH_CMD_OFF) & apb.pwdata_i[0]));

      sgdmac_cfg_ch #(.CNT_W(CNT_W)) u_ch (
         .clk        (clk),
         .rst        (rst),
         .addr_wr    (addr_wr[n]),
         .cmd_wr     (cmd_wr[n]),
         .wdata      (apb.pwdata_i),
         .done       (done_i[n]),
         .start_addr (start_addr_o[32*n +: 32]),
         .start      (start_o[n]),
         .busy       (busy[n]),
         .blocked    (blocked[n]),
         .fin        (fin[n]),
         .done_cnt   (done_cnt[n])
      );
   end

   // Decode defaults to an error so every unmatched address/direction is rejected.
   always_comb begin
      setup_dat = '0;
      setup_err = 1'b1;
      case (apb.paddr_i)
         VERSION_OFF: if (!apb.pwrite_i) begin
            setup_err = 1'b0;
            setup_dat = VERSION_BASE | 32'(CH_CNT);
         end
         INT_EN_OFF: begin
            setup_err = 1'b0;
            if (!apb.pwrite_i) setup_dat = 32'(int_en);
         end
         INT_STATUS_OFF: begin
            setup_err = 1'b0;
            if (!apb.pwrite_i) setup_dat = 32'(int_status);
         end
         default: ;
      endcase
      for (int n = 0; n < CH_CNT; n++) begin
         if (ch_hit[n]) begin
            case (off)
               CH_ADDR_OFF: begin
                  setup_err = apb.pwrite_i && ((apb.pwdata_i & ALIGN_MASK) != 32'h0);
                  if (!apb.pwrite_i) setup_dat = start_addr_o[32*n +: 32];
               end
               CH_CMD_OFF:    setup_err = !apb.pwrite_i;
               CH_STATUS_OFF: if (!apb.pwrite_i) begin
                  setup_err = 1'b0;
                  setup_dat = {31'b0, busy[n]};
               end
               CH_CNT_OFF:    if (!apb.pwrite_i) begin
                  setup_err = 1'b0;
                  setup_dat = 32'(done_cnt[n]);
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prdata_q   <= '0;
         pslverr_q  <= 1'b0;
         int_en     <= '0;
         int_status <= '0;
      end else begin
         if (setup) begin
            prdata_q  <= setup_dat;
            pslverr_q <= setup_err;
         end
         if (wr_commit && apb.paddr_i == INT_EN_OFF) int_en <= apb.pwdata_i[CH_CNT-1:0];
         // A completion in the same cycle as the clear keeps its bit set.
         int_status <= ((wr_commit && apb.paddr_i == INT_STATUS_OFF)
                        ? (int_status & ~apb.pwdata_i[CH_CNT-1:0]) : int_status) | fin;
      end
   end

   assign apb.pready_o  = access;
   assign apb.prdata_o  = (access & ~apb.pwrite_i) ? prdata_q : 32'h0;
   assign apb.pslverr_o = access & (pslverr_q | (apb.pwrite_i & |live_rej));
   assign irq_o         = |(int_status & int_en);
endmodule
